prio_mixer_n: RTL and testbench
===============================

// Module: prio_mixer_n
// PURPOSE
//  Parametrised N-layer pixel priority mixer with CPU-programmable priority tables.
//  Each layer pixel's 2-bit priority select indexes that layer's 4-entry table.
//  The mixer picks the highest-priority opaque layer and can pen-blend the top two layers.
//  CPU writes are double-buffered and committed at vblank. The block sits between the
//  layer generators and the palette lookup.
// PARAMETERS
//  NUM_LAYERS  4   layers mixed, 2..8; layer 0 is the backdrop
//  COLOR_W     14  per-layer colour width: [COLOR_W-1 -: 2] prio select, [3:0] pen
//  SS_IDX      -1  save-state bus index
// PORTS
//  clk        in   1                    clock
//  reset      in   1                    synchronous, active-high
//  ce_pixel   in   1                    pixel enable; pipeline advances only when high
//  vblank     in   1                    vertical blank level
//  color_in   in   NUM_LAYERS*COLOR_W   layer i at [i*COLOR_W +: COLOR_W]
//  color_out  out  COLOR_W              mixed pixel
//  cs         in   1                    CPU select
//  cpu_addr   in   4                    word address
//  cpu_rw     in   1                    1=read, 0=write
//  cpu_ds_n   in   2                    byte strobes, active low: [1]=hi byte, [0]=lo byte
//  cpu_din    in   16                   write data
//  cpu_dout   out  16                   read data
//  ssbus      ssbus_if.slave            save-state access to the active register bank
// BEHAVIOUR
//  Register map (16-bit words, pending bank P and active bank A):
//   0: CTRL[0] shadow_en, CTRL[1] blend_en, other bits read 0
//   1+i (i<NUM_LAYERS): PTAB[i], nibble k = priority for prio select k; others read 0
//  Writes: on cs & ~cpu_rw, store each byte whose strobe is low into P.
//   With shadow_en=0 (in A), the same write also goes to A in that cycle.
//  Commit: on the rising edge of vblank with shadow_en=1, copy A<=P in one cycle.
//   If a CPU write lands in the commit cycle, the write goes to P and also to A.
//  Reads: on cs & cpu_rw, cpu_dout<=P[addr] on the next cycle; holds otherwise.
//  ssbus: 16 entries, read/write A[addr]; a write acks in the same cycle.
//  Mixing pipeline, 3 ce_pixel stages, latency = 3 ce_pixel pulses:
//   S1: p[i]=PTAB[i] nibble at sel[i]; opaque[i]=|pen[i] (layer 0 is always opaque).
//   S2: top T = highest p among opaque layers; second S = highest of the rest.
//       Ties go to the higher layer index.
//   S3: if blend_en & (p[T]==p[S]+1) & S!=0, out={T[COLOR_W-1:4],S[3:0]};
//       otherwise out=T. Comparisons are 4-bit unsigned; p[S]=15 never blends (no wrap).
//  Stalls: when ce_pixel is low, all stages and color_out hold.
//  Reset: A, P, all pipe regs, color_out and cpu_dout go to 0. A mid-frame reset
//   flushes in-flight pixels to 0.
// STRUCTURE
//  Package prio_mixer_pkg: PRIO_W=4, REG_CTRL=0, REG_PTAB0=1, typedef prio_t, ctrl_t.
//  Sub-module prio_mixer_regs: P/A banks, byte strobes, vblank commit, ssbus.
//  prio_mixer_n instantiates prio_mixer_regs and holds the S1-S3 pipeline.
// TESTING
//  1 reset, then PTAB0=0x1111 and PTAB1=0x2222 with shadow_en=0; L1 pen 5, L0 pen 3
//    -> L1 colour appears after 3 ce_pixel pulses.
//  2 same setup with L1 pen 0 -> L0 colour (transparent layer skipped).
//  3 shadow_en=1; write PTAB1=0x0000 -> mix unchanged until the vblank rising edge,
//    then L0 wins; read-back of PTAB1 returns 0x0000 immediately.
//  4 blend_en=1, p0=3, p1=4, L1=0x1A5, L0=0x0C2 -> out=0x1A2; with p1=5 -> 0x1A5.
//  5 NUM_LAYERS=4, all PTAB=0x7777, all pens nonzero -> L3 wins (tie rule).
//    Toggle ce_pixel 1-in-4 -> output holds between pulses.
//  6 byte write with ds_n=2'b10 to PTAB2 holding 0xFFFF, data 0x1234 -> reads 0xFF34.
//    Reset asserted mid-stream -> color_out=0 in the next cycle.

Source files
------------

// File: rtl/prio_mixer_pkg.sv
// Shared types, register map and helpers for the priority mixer.
package prio_mixer_pkg;

    localparam int PRIO_W    = 4;
    localparam int REG_CTRL  = 0;
    localparam int REG_PTAB0 = 1;

    typedef logic [PRIO_W-1:0] prio_t;

    // CTRL word layout: bit 1 blend_en, bit 0 shadow_en.
    typedef struct packed {
        logic blend_en;
        logic shadow_en;
    } ctrl_t;

    // Merge a 16-bit write into an existing word; a low strobe selects the byte.
    function automatic logic [15:0] merge_bytes(input logic [15:0] old_w,
                                                input logic [15:0] new_w,
                                                input logic [1:0]  ds_n);
        logic [15:0] r;
        r = old_w;
        if (!ds_n[1]) r[15:8] = new_w[15:8];
        if (!ds_n[0]) r[7:0]  = new_w[7:0];
        return r;
    endfunction

endpackage

// File: rtl/ssbus_if.sv
// Save-state access bus: single-cycle word reads and writes of a 16-entry window.
interface ssbus_if;
    logic        select;
    logic [7:0]  idx;
    logic [3:0]  addr;
    logic        rd;
    logic        wr;
    logic [15:0] din;
    logic [15:0] dout;
    logic        ack;

    modport slave  (input select, idx, addr, rd, wr, din, output dout, ack);
    modport master (output select, idx, addr, rd, wr, din, input dout, ack);
endinterface

// File: rtl/prio_mixer_regs.sv
// Pending/active register banks for the priority mixer: CPU byte writes into the
// pending bank (optionally written through), vblank commit, CPU read-back of the
// pending bank and save-state access to the active bank.
module prio_mixer_regs
    import prio_mixer_pkg::*;
#(
    parameter int NUM_LAYERS = 4,
    parameter int SS_IDX     = -1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     vblank_i,
    input  logic                     cs_i,
    input  logic [3:0]               cpu_addr_i,
    input  logic                     cpu_rw_i,
    input  logic [1:0]               cpu_ds_n_i,
    input  logic [15:0]              cpu_din_i,
    output logic [15:0]              cpu_dout_o,
    output ctrl_t                    ctrl_a_o,
    output logic [NUM_LAYERS*16-1:0] ptab_a_o,
    ssbus_if.slave                   ssbus
);

    localparam logic [7:0] SS_IDX_B = 8'(SS_IDX);
    localparam logic [3:0] CTRL_A   = 4'(REG_CTRL);

    ctrl_t ctrl_p_q, ctrl_p_d;
    ctrl_t ctrl_a_q, ctrl_a_d;
    logic  vblank_q;
    logic [15:0] cpu_dout_q;

    logic [NUM_LAYERS*16-1:0] ptab_p_w;
    logic [NUM_LAYERS*16-1:0] ptab_a_w;

    logic cpu_wr;
    logic cpu_rd;
    logic commit;
    logic wr_thru;
    logic ss_sel;
    logic ss_wr;
    logic [15:0] rd_word_p;
    logic [15:0] rd_word_a;

    assign cpu_wr  = cs_i & ~cpu_rw_i;
    assign cpu_rd  = cs_i &  cpu_rw_i;
    // A commit only happens while shadowing; a write in that same cycle lands in both banks.
    assign commit  = vblank_i & ~vblank_q & ctrl_a_q.shadow_en;
    assign wr_thru = cpu_wr & (~ctrl_a_q.shadow_en | commit);

    // A negative bus index means this block answers regardless of idx.
    assign ss_sel  = ssbus.select & ((SS_IDX < 0) | (ssbus.idx == SS_IDX_B));
    assign ss_wr   = ss_sel & ssbus.wr;

    // Next state of the control word in both banks; save-state writes apply last.
    always_comb begin
        ctrl_p_d = ctrl_p_q;
        ctrl_a_d = commit ? ctrl_p_q : ctrl_a_q;
        if (cpu_wr && cpu_addr_i == CTRL_A && !cpu_ds_n_i[0]) begin
            ctrl_p_d = ctrl_t'(cpu_din_i[1:0]);
            if (wr_thru) ctrl_a_d = ctrl_t'(cpu_din_i[1:0]);
        end
        if (ss_wr && ssbus.addr == CTRL_A) begin
            ctrl_a_d = ctrl_t'(ssbus.din[1:0]);
        end
    end

    // Control word storage and vblank edge history.
    always_ff @(posedge clk) begin
        if (reset) begin
            ctrl_p_q <= '0;
            ctrl_a_q <= '0;
            vblank_q <= 1'b0;
        end else begin
            ctrl_p_q <= ctrl_p_d;
            ctrl_a_q <= ctrl_a_d;
            vblank_q <= vblank_i;
        end
    end

    // One pending/active priority table pair per layer.
    generate
        for (genvar gi = 0; gi < NUM_LAYERS; gi++) begin : g_ptab
            localparam logic [3:0] ADDR = 4'(REG_PTAB0 + gi);

            logic [15:0] p_q, p_d;
            logic [15:0] a_q, a_d;

            // Pending takes CPU writes; active takes commit, write-through and save-state.
            always_comb begin
                p_d = p_q;
                a_d = commit ? p_q : a_q;
                if (cpu_wr && cpu_addr_i == ADDR) begin
                    p_d = merge_bytes(p_q, cpu_din_i, cpu_ds_n_i);
                    if (wr_thru) a_d = merge_bytes(a_d, cpu_din_i, cpu_ds_n_i);
                end
                if (ss_wr && ssbus.addr == ADDR) begin
                    a_d = ssbus.din;
                end
            end

            // Table word storage.
            always_ff @(posedge clk) begin
                if (reset) begin
                    p_q <= '0;
                    a_q <= '0;
                end else begin
                    p_q <= p_d;
                    a_q <= a_d;
                end
            end

            assign ptab_p_w[gi*16 +: 16] = p_q;
            assign ptab_a_w[gi*16 +: 16] = a_q;
        end
    endgenerate

    // Word decode for pending-bank (CPU) and active-bank (save-state) reads.
    always_comb begin
        rd_word_p = '0;
        rd_word_a = '0;
        if (cpu_addr_i == CTRL_A) rd_word_p = {14'b0, ctrl_p_q};
        if (ssbus.addr == CTRL_A) rd_word_a = {14'b0, ctrl_a_q};
        for (int i = 0; i < NUM_LAYERS; i++) begin
            if (int'(cpu_addr_i) == REG_PTAB0 + i) rd_word_p = ptab_p_w[i*16 +: 16];
            if (int'(ssbus.addr) == REG_PTAB0 + i) rd_word_a = ptab_a_w[i*16 +: 16];
        end
    end

    // CPU read data is registered and held between reads.
    always_ff @(posedge clk) begin
        if (reset) begin
            cpu_dout_q <= '0;
        end else if (cpu_rd) begin
            cpu_dout_q <= rd_word_p;
        end
    end

    assign cpu_dout_o = cpu_dout_q;
    assign ctrl_a_o   = ctrl_a_q;
    assign ptab_a_o   = ptab_a_w;
    assign ssbus.dout = rd_word_a;
    assign ssbus.ack  = ss_sel & (ssbus.rd | ssbus.wr);

endmodule

// File: rtl/prio_mixer_n.sv
// N-layer pixel priority mixer: per-layer priority lookup, top/second selection
// and optional pen blend, as a three-stage pipeline advancing on ce_pixel.
module prio_mixer_n
    import prio_mixer_pkg::*;
#(
    parameter int NUM_LAYERS = 4,
    parameter int COLOR_W    = 14,
    parameter int SS_IDX     = -1
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          ce_pixel,
    input  logic                          vblank,
    input  logic [NUM_LAYERS*COLOR_W-1:0] color_in,
    output logic [COLOR_W-1:0]            color_out,
    input  logic                          cs,
    input  logic [3:0]                    cpu_addr,
    input  logic                          cpu_rw,
    input  logic [1:0]                    cpu_ds_n,
    input  logic [15:0]                   cpu_din,
    output logic [15:0]                   cpu_dout,
    ssbus_if.slave                        ssbus
);

    ctrl_t                    ctrl_a;
    logic [NUM_LAYERS*16-1:0] ptab_a;

    prio_mixer_regs #(
        .NUM_LAYERS (NUM_LAYERS),
        .SS_IDX     (SS_IDX)
    ) u_regs (
        .clk        (clk),
        .reset      (reset),
        .vblank_i   (vblank),
        .cs_i       (cs),
        .cpu_addr_i (cpu_addr),
        .cpu_rw_i   (cpu_rw),
        .cpu_ds_n_i (cpu_ds_n),
        .cpu_din_i  (cpu_din),
        .cpu_dout_o (cpu_dout),
        .ctrl_a_o   (ctrl_a),
        .ptab_a_o   (ptab_a),
        .ssbus      (ssbus)
    );

    // ---------------- S1: per-layer priority lookup ----------------
    logic [NUM_LAYERS*COLOR_W-1:0] s1_col_w;
    logic [NUM_LAYERS*PRIO_W-1:0]  s1_pri_w;
    logic [NUM_LAYERS-1:0]         s1_opq_w;

    generate
        for (genvar gi = 0; gi < NUM_LAYERS; gi++) begin : g_s1
            logic [COLOR_W-1:0] col;
            logic [1:0]         sel;
            logic [15:0]        tab;
            prio_t              pri_d;
            logic [COLOR_W-1:0] col_q;
            prio_t              pri_q;

            assign col   = color_in[gi*COLOR_W +: COLOR_W];
            assign sel   = col[COLOR_W-1 -: 2];
            assign tab   = ptab_a[gi*16 +: 16];
            assign pri_d = tab[{sel, 2'b00} +: PRIO_W];

            // Capture the layer colour with its looked-up priority.
            always_ff @(posedge clk) begin
                if (reset) begin
                    col_q <= '0;
                    pri_q <= '0;
                end else if (ce_pixel) begin
                    col_q <= col;
                    pri_q <= pri_d;
                end
            end

            assign s1_col_w[gi*COLOR_W +: COLOR_W] = col_q;
            assign s1_pri_w[gi*PRIO_W +: PRIO_W]   = pri_q;

            if (gi == 0) begin : g_backdrop
                // The backdrop always participates, even with pen 0.
                assign s1_opq_w[gi] = 1'b1;
            end else begin : g_layer
                logic opq_q;
                // Pen 0 marks a transparent pixel.
                always_ff @(posedge clk) begin
                    if (reset) begin
                        opq_q <= 1'b0;
                    end else if (ce_pixel) begin
                        opq_q <= |col[3:0];
                    end
                end
                assign s1_opq_w[gi] = opq_q;
            end
        end
    endgenerate

    // ---------------- S2: top and second selection ----------------
    logic [COLOR_W-1:0] top_col_d, sec_col_d;
    prio_t              top_pri_d, sec_pri_d;
    logic               sec_vld_d;
    logic [3:0]         top_idx;

    logic [COLOR_W-1:0] s2_top_col_q, s2_sec_col_q;
    prio_t              s2_top_pri_q, s2_sec_pri_q;
    logic               s2_sec_vld_q;

    // Scan upward with >= so equal priorities resolve to the higher layer index.
    always_comb begin
        top_col_d = s1_col_w[0 +: COLOR_W];
        top_pri_d = s1_pri_w[0 +: PRIO_W];
        top_idx   = '0;
        for (int i = 1; i < NUM_LAYERS; i++) begin
            if (s1_opq_w[i] && s1_pri_w[i*PRIO_W +: PRIO_W] >= top_pri_d) begin
                top_col_d = s1_col_w[i*COLOR_W +: COLOR_W];
                top_pri_d = s1_pri_w[i*PRIO_W +: PRIO_W];
                top_idx   = 4'(i);
            end
        end
        sec_col_d = '0;
        sec_pri_d = '0;
        sec_vld_d = 1'b0;
        for (int i = 0; i < NUM_LAYERS; i++) begin
            if (s1_opq_w[i] && (4'(i) != top_idx) &&
                (!sec_vld_d || s1_pri_w[i*PRIO_W +: PRIO_W] >= sec_pri_d)) begin
                sec_col_d = s1_col_w[i*COLOR_W +: COLOR_W];
                sec_pri_d = s1_pri_w[i*PRIO_W +: PRIO_W];
                sec_vld_d = 1'b1;
            end
        end
    end

    // Register the winning pair.
    always_ff @(posedge clk) begin
        if (reset) begin
            s2_top_col_q <= '0;
            s2_sec_col_q <= '0;
            s2_top_pri_q <= '0;
            s2_sec_pri_q <= '0;
            s2_sec_vld_q <= 1'b0;
        end else if (ce_pixel) begin
            s2_top_col_q <= top_col_d;
            s2_sec_col_q <= sec_col_d;
            s2_top_pri_q <= top_pri_d;
            s2_sec_pri_q <= sec_pri_d;
            s2_sec_vld_q <= sec_vld_d;
        end
    end

    // ---------------- S3: optional pen blend ----------------
    logic               blend;
    logic [COLOR_W-1:0] out_d;
    logic [COLOR_W-1:0] out_q;

    // Compare in 5 bits so a second priority of 15 can never match via wrap.
    assign blend = ctrl_a.blend_en & s2_sec_vld_q & (s2_sec_col_q != '0) &
                   ({1'b0, s2_top_pri_q} == ({1'b0, s2_sec_pri_q} + 5'd1));
    assign out_d = blend ? {s2_top_col_q[COLOR_W-1:4], s2_sec_col_q[3:0]} : s2_top_col_q;

    // Output pixel register.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_q <= '0;
        end else if (ce_pixel) begin
            out_q <= out_d;
        end
    end

    assign color_out = out_q;

endmodule

// File: tb/tb_prio_mixer_n.sv
// Directed bench for prio_mixer_n with an expected-pixel scoreboard.
module tb_prio_mixer_n;

    localparam int NL = 4;
    localparam int CW = 14;

    logic           clk = 1'b0;
    logic           reset;
    logic           ce_pixel;
    logic           vblank;
    logic [NL*CW-1:0] color_in;
    logic [CW-1:0]  color_out;
    logic           cs;
    logic [3:0]     cpu_addr;
    logic           cpu_rw;
    logic [1:0]     cpu_ds_n;
    logic [15:0]    cpu_din;
    logic [15:0]    cpu_dout;

    ssbus_if ss_bus ();

    prio_mixer_n #(.NUM_LAYERS(NL), .COLOR_W(CW), .SS_IDX(-1)) dut (
        .clk       (clk),
        .reset     (reset),
        .ce_pixel  (ce_pixel),
        .vblank    (vblank),
        .color_in  (color_in),
        .color_out (color_out),
        .cs        (cs),
        .cpu_addr  (cpu_addr),
        .cpu_rw    (cpu_rw),
        .cpu_ds_n  (cpu_ds_n),
        .cpu_din   (cpu_din),
        .cpu_dout  (cpu_dout),
        .ssbus     (ss_bus)
    );

    always #5 clk = ~clk;

    int          n_chk = 0;
    int          n_err = 0;
    logic [15:0] sb[$];
    logic [15:0] last_exp = '0;

    function automatic logic [NL*CW-1:0] mk(input logic [CW-1:0] c0, input logic [CW-1:0] c1,
                                            input logic [CW-1:0] c2, input logic [CW-1:0] c3);
        return {c3, c2, c1, c0};
    endfunction

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_chk++;
        $display("check %-10s got=%04h exp=%04h", tag, got, exp);
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed %04h expected %04h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One ce_pixel pulse; the pixel entering now emerges two pulses later.
    task automatic pix(input string tag, input logic [NL*CW-1:0] cv, input logic [15:0] exp);
        color_in = cv;
        ce_pixel = 1'b1;
        tick();
        ce_pixel = 1'b0;
        sb.push_back(exp);
        if (sb.size() >= 3) begin
            last_exp = sb.pop_front();
            chk(tag, {2'b0, color_out}, last_exp);
        end
    endtask

    task automatic cpu_wr(input logic [3:0] a, input logic [15:0] d, input logic [1:0] dsn);
        cs = 1'b1; cpu_rw = 1'b0; cpu_addr = a; cpu_din = d; cpu_ds_n = dsn;
        tick();
        cs = 1'b0; cpu_ds_n = 2'b11;
    endtask

    task automatic cpu_rd(input string tag, input logic [3:0] a, input logic [15:0] exp);
        cs = 1'b1; cpu_rw = 1'b1; cpu_addr = a;
        tick();
        cs = 1'b0;
        chk(tag, cpu_dout, exp);
    endtask

    task automatic ss_rd(input string tag, input logic [3:0] a, input logic [15:0] exp);
        ss_bus.select = 1'b1; ss_bus.rd = 1'b1; ss_bus.addr = a;
        #1;
        chk({tag, "_ack"}, {15'b0, ss_bus.ack}, 16'h0001);
        chk(tag, ss_bus.dout, exp);
        ss_bus.select = 1'b0; ss_bus.rd = 1'b0;
    endtask

    task automatic vblank_pulse();
        vblank = 1'b1; tick();
        vblank = 1'b0; tick();
    endtask

    logic [NL*CW-1:0] pa, pb, pc, pd, pe, junk;

    initial begin
        reset = 1'b1; ce_pixel = 1'b0; vblank = 1'b0; color_in = '0;
        cs = 1'b0; cpu_addr = '0; cpu_rw = 1'b1; cpu_ds_n = 2'b11; cpu_din = '0;
        ss_bus.select = 1'b0; ss_bus.idx = '0; ss_bus.addr = '0;
        ss_bus.rd = 1'b0; ss_bus.wr = 1'b0; ss_bus.din = '0;

        pa   = mk(14'h00A3, 14'h2155, 14'h0000, 14'h0000);
        pb   = mk(14'h00A3, 14'h2150, 14'h0000, 14'h0000);
        pc   = mk(14'h00C2, 14'h01A5, 14'h0000, 14'h0000);
        pd   = mk(14'h0001, 14'h0012, 14'h0023, 14'h0034);
        pe   = mk(14'h0001, 14'h0012, 14'h0023, 14'h0030);
        junk = mk(14'h3FFF, 14'h3FFE, 14'h1FFD, 14'h2FFC);

        // Reset state
        repeat (3) tick();
        chk("rst_out", {2'b0, color_out}, 16'h0000);
        chk("rst_dout", cpu_dout, 16'h0000);
        reset = 1'b0;
        sb.push_back(16'h0000);
        sb.push_back(16'h0000);

        // 1/2: direct writes; opaque L1 wins, transparent L1 falls back to L0
        cpu_wr(4'd1, 16'h1111, 2'b00);
        cpu_wr(4'd2, 16'h2222, 2'b00);
        pix("t1_pix", pa, 16'h2155);
        pix("t1_pix", pa, 16'h2155);
        pix("t1_pix", pb, 16'h00A3);
        pix("t1_pix", pa, 16'h2155);
        pix("t2_pix", pb, 16'h00A3);
        pix("t2_pix", pb, 16'h00A3);
        pix("t1_pix", pa, 16'h2155);

        // 3: shadowed write is invisible to the mix until vblank rises
        cpu_wr(4'd0, 16'h0001, 2'b00);
        cpu_wr(4'd2, 16'h0000, 2'b00);
        cpu_rd("t3_rdP", 4'd2, 16'h0000);
        ss_rd("t3_ssA", 4'd2, 16'h2222);
        pix("t3_pre", pa, 16'h2155);
        pix("t3_pre", pa, 16'h2155);
        pix("t3_pre", pa, 16'h2155);
        vblank_pulse();
        sb.delete();
        ss_rd("t3_ssA2", 4'd2, 16'h0000);
        repeat (4) pix("t3_post", pa, 16'h00A3);

        // 4: blend when p[T] = p[S]+1
        cpu_wr(4'd0, 16'h0002, 2'b00);
        cpu_wr(4'd1, 16'h0003, 2'b00);
        cpu_wr(4'd2, 16'h0004, 2'b00);
        cpu_rd("t4_rdC", 4'd0, 16'h0002);
        vblank_pulse();
        sb.delete();
        repeat (4) pix("t4_blend", pc, 16'h01A2);
        cpu_wr(4'd2, 16'h0005, 2'b00);
        sb.delete();
        repeat (4) pix("t4_noblnd", pc, 16'h01A5);

        // 5: equal priorities resolve to the higher layer; stalls hold the output
        for (int i = 1; i <= NL; i++) cpu_wr(4'(i), 16'h7777, 2'b00);
        sb.delete();
        pix("t5_tie", pd, 16'h0034);
        pix("t5_tie", pe, 16'h0023);
        pix("t5_tie", pd, 16'h0034);
        pix("t5_tie", pd, 16'h0034);
        pix("t5_tie", pe, 16'h0023);
        for (int k = 0; k < 4; k++) begin
            pix("t5_pulse", (k[0] ? pe : pd), (k[0] ? 16'h0023 : 16'h0034));
            color_in = junk;
            for (int j = 0; j < 3; j++) begin
                tick();
                chk("t5_hold", {2'b0, color_out}, last_exp);
            end
        end

        // 6: byte strobes, then a mid-stream reset
        cpu_wr(4'd3, 16'hFFFF, 2'b00);
        cpu_wr(4'd3, 16'h1234, 2'b10);
        cpu_rd("t6_lo", 4'd3, 16'hFF34);
        cpu_wr(4'd3, 16'hAB99, 2'b01);
        cpu_rd("t6_hi", 4'd3, 16'hAB34);
        color_in = pd;
        ce_pixel = 1'b1;
        reset = 1'b1;
        tick();
        chk("t6_rst", {2'b0, color_out}, 16'h0000);
        reset = 1'b0;
        ce_pixel = 1'b0;
        cpu_rd("t6_rdrst", 4'd3, 16'h0000);
        sb.delete();
        sb.push_back(16'h0000);
        sb.push_back(16'h0000);
        repeat (4) pix("t6_flush", pd, 16'h0034);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
